// File: rtl/counter_cmd_arbiter.sv
// Command arbiter for the 4-digit up/down counter: debounced buttons plus optional UART
// commands (build macro CMD_UART_EN) drive the STOP/RUN/CLEAR FSM and the up/down mode.
module counter_cmd_arbiter #(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int DROP_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_mode,
  input  logic              btn_run_stop,
  input  logic              btn_clear,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              run_stop,
  output logic              clear,
  output logic              mode,
  output logic [1:0]        led_mode,
  output logic [1:0]        led_run_stop,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [1:0]        dbg_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {ST_STOP = 2'd0, ST_RUN = 2'd1, ST_CLEAR = 2'd2} state_t;

  // Command vectors are one-hot: bit 0 = mode, bit 1 = run/stop, bit 2 = clear.
  logic [2:0]    btn_raw, sync1, sync2, db, db_q, btn_rise;
  logic [CW-1:0] db_cnt [3];
  logic [2:0]    btn_pend, btn_pick, btn_grant, btn_drop, cmd;
  logic [2:0]    uart_cmd_g;
  logic          uart_win, uart_grant, uart_drop, grant_en;
  logic [2:0]    n_drop;
  logic [DROP_W:0] drop_sum;
  state_t        state, state_next;

  assign btn_raw  = {btn_clear, btn_run_stop, btn_mode};
  assign btn_rise = db & ~db_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    btn_pick = 3'b000;
    if (btn_pend[2])      btn_pick = 3'b100;
    else if (btn_pend[1]) btn_pick = 3'b010;
    else if (btn_pend[0]) btn_pick = 3'b001;
  end

  // Nothing is granted while the clear pulse is out; pending flags simply wait.
  assign grant_en   = (state != ST_CLEAR);
  assign btn_grant  = (grant_en && !uart_win) ? btn_pick : 3'b000;
  assign uart_grant = grant_en && uart_win;
  assign cmd        = btn_grant | (uart_grant ? uart_cmd_g : 3'b000);
  assign btn_drop   = btn_rise & btn_pend & ~btn_grant;

`ifdef CMD_UART_EN
  logic       uart_pend, last_src;
  logic [2:0] rx_cmd;

  always_comb begin
    rx_cmd = 3'b000;
    case (rx_data)
      8'h72:   rx_cmd = 3'b010;
      8'h63:   rx_cmd = 3'b100;
      8'h6D:   rx_cmd = 3'b001;
      default: rx_cmd = 3'b000;
    endcase
  end

  // last_src: 1 = UART won the previous grant, so buttons win the next tie.
  assign rx_ready = !uart_pend;
  assign uart_win = uart_pend && ((btn_pend == 3'b000) || !last_src);
  // The receiver strobes rx_valid once per byte, so a command byte offered while busy is lost.
  assign uart_drop = rx_valid && !rx_ready && (rx_cmd != 3'b000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_pend  <= 1'b0;
      uart_cmd_g <= 3'b000;
      last_src   <= 1'b1;
    end else begin
      if (rx_valid && rx_ready && (rx_cmd != 3'b000)) begin
        uart_pend  <= 1'b1;
        uart_cmd_g <= rx_cmd;
      end else if (uart_grant) begin
        uart_pend <= 1'b0;
      end
      if (uart_grant)               last_src <= 1'b1;
      else if (btn_grant != 3'b000) last_src <= 1'b0;
    end
  end
`else
  logic unused_rx;
  assign unused_rx  = &{1'b0, rx_valid, rx_data};
  assign rx_ready   = 1'b0;
  assign uart_win   = 1'b0;
  assign uart_drop  = 1'b0;
  assign uart_cmd_g = 3'b000;
`endif

  assign n_drop   = 3'(btn_drop[0]) + 3'(btn_drop[1]) + 3'(btn_drop[2]) + 3'(uart_drop);
  assign drop_sum = {1'b0, drop_cnt} + (DROP_W + 1)'(n_drop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_pend <= '0;
      drop_cnt <= '0;
      mode     <= 1'b0;
      state    <= ST_STOP;
    end else begin
      btn_pend <= (btn_pend & ~btn_grant) | btn_rise;
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      if (cmd[0]) mode <= ~mode;
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_STOP: begin
        if (cmd[1])      state_next = ST_RUN;
        else if (cmd[2]) state_next = ST_CLEAR;
      end
      ST_RUN:   if (cmd[1]) state_next = ST_STOP;
      ST_CLEAR: state_next = ST_STOP;
      default:  state_next = ST_STOP;
    endcase
  end

  always_comb begin
    run_stop     = (state == ST_RUN);
    clear        = (state == ST_CLEAR);
    led_mode     = mode ? 2'b10 : 2'b01;
    led_run_stop = 2'b01;
    if (state == ST_RUN)   led_run_stop = 2'b10;
    if (state == ST_CLEAR) led_run_stop = 2'b00;
    dbg_state    = state;
  end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Directed bench for counter_cmd_arbiter; UART scenarios are built only with CMD_UART_EN,
// otherwise the tied-off UART port is exercised instead.
module tb_counter_cmd_arbiter;
  localparam int DB = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_mode = 1'b0, btn_run_stop = 1'b0, btn_clear = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, run_stop, clear, mode;
  logic [1:0]    led_mode, led_run_stop, dbg_state;
  logic [DW-1:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  counter_cmd_arbiter #(.DEBOUNCE_CYCLES(DB), .DROP_W(DW)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_run_stop(btn_run_stop), .btn_clear(btn_clear),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .run_stop(run_stop), .clear(clear), .mode(mode),
    .led_mode(led_mode), .led_run_stop(led_run_stop),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then park on the falling edge for driving and sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // One-cycle rx_valid strobe; returns on the falling edge after the accepting edge.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    step(2);
    check("reset_run_stop", run_stop, 0);
    check("reset_clear", clear, 0);
    check("reset_mode", mode, 0);
    check("reset_led_mode", led_mode, 2'b01);
    check("reset_led_rs", led_run_stop, 2'b01);
    check("reset_drop", drop_cnt, 0);
`ifdef CMD_UART_EN
    check("reset_rx_ready", rx_ready, 1);
`else
    check("reset_rx_ready", rx_ready, 0);
`endif

    // 3-cycle glitch is one sample short of the debounce window.
    btn_run_stop = 1'b1; step(3); btn_run_stop = 1'b0; step(15);
    check("glitch_run_stop", run_stop, 0);

    btn_run_stop = 1'b1; step(10);
    check("hold_run_stop", run_stop, 1);
    check("hold_led_rs", led_run_stop, 2'b10);
    btn_run_stop = 1'b0; step(10);
    btn_run_stop = 1'b1; step(10);
    check("repress_run_stop", run_stop, 0);
    check("repress_led_rs", led_run_stop, 2'b01);
    btn_run_stop = 1'b0; step(10);

    // Button clear from STOP: pending after 7 edges, CLEAR for exactly the next cycle.
    btn_clear = 1'b1; step(7);
    check("bclr_before", clear, 0);
    step(1);
    check("bclr_pulse", clear, 1);
    check("bclr_led_rs", led_run_stop, 2'b00);
    step(1);
    check("bclr_after", clear, 0);
    check("bclr_after_led", led_run_stop, 2'b01);
    btn_clear = 1'b0; step(10);

    btn_run_stop = 1'b1; step(10); btn_run_stop = 1'b0; step(10);
    check("run_again", run_stop, 1);
    btn_clear = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("bclr_in_run", clear, 0);
    end
    check("bclr_in_run_state", run_stop, 1);
    btn_clear = 1'b0; step(10);

    btn_mode = 1'b1; step(10);
    check("bmode_mode", mode, 1);
    check("bmode_led", led_mode, 2'b10);
    btn_mode = 1'b0; step(10);

    // Asynchronous reset mid-RUN takes effect before the next clock edge.
    reset = 1'b1; #1;
    check("areset_run_stop", run_stop, 0);
    check("areset_led_rs", led_run_stop, 2'b01);
    check("areset_mode", mode, 0);
    check("areset_drop", drop_cnt, 0);
    step(2); reset = 1'b0; step(2);

`ifdef CMD_UART_EN
    // Tie from reset: buttons win first, then UART 'r'.
    btn_mode = 1'b1; step(6);
    send(8'h72);
    check("rr1_idle", mode, 0);
    step(1);
    check("rr1_mode_first", mode, 1);
    check("rr1_not_run_yet", run_stop, 0);
    step(1);
    check("rr1_run", run_stop, 1);
    btn_mode = 1'b0; step(10);
    btn_mode = 1'b1; step(10);
    check("solo_mode", mode, 0);
    btn_mode = 1'b0; step(10);
    // Last grant was a button, so UART wins this tie.
    btn_mode = 1'b1; step(6);
    send(8'h72);
    step(1);
    check("rr2_uart_first", run_stop, 0);
    check("rr2_mode_wait", mode, 0);
    step(1);
    check("rr2_mode_second", mode, 1);
    btn_mode = 1'b0; step(10);

    send(8'h63);
    check("uclr_before", clear, 0);
    step(1);
    check("uclr_pulse", clear, 1);
    check("uclr_led_rs", led_run_stop, 2'b00);
    step(1);
    check("uclr_after", clear, 0);
    check("uclr_stop", led_run_stop, 2'b01);

    send(8'h72); step(1);
    check("ur_run", run_stop, 1);
    send(8'h63); step(1);
    check("uclr_run_nopulse", clear, 0);
    check("uclr_run_state", run_stop, 1);
    step(1);
    check("uclr_run_nopulse2", clear, 0);

    send(8'h41);
    check("junk_ready", rx_ready, 1);
    step(2);
    check("junk_drop", drop_cnt, 0);
    check("junk_run", run_stop, 1);
    check("junk_mode", mode, 1);

    // Second 'm' arrives while the first is still pending.
    rx_valid = 1'b1; rx_data = 8'h6D;
    @(posedge clk); @(negedge clk);
    check("drop_busy_ready", rx_ready, 0);
    @(posedge clk); @(negedge clk);
    rx_valid = 1'b0;
    check("drop_one", drop_cnt, 1);
    check("drop_mode_once", mode, 0);
    step(2);

    rx_valid = 1'b1; rx_data = 8'h6D;
    step(700);
    rx_valid = 1'b0; step(2);
    check("drop_saturate", drop_cnt, 8'hFF);
    reset = 1'b1; #1;
    check("drop_reset", drop_cnt, 0);
    step(1); reset = 1'b0; step(2);
`else
    rx_valid = 1'b1; rx_data = 8'h72; step(5);
    check("off_rx_ready", rx_ready, 0);
    check("off_state_stop", run_stop, 0);
    rx_valid = 1'b0; step(2);
`endif

    // Three buttons together: clear, then run/stop, then mode.
    btn_mode = 1'b1; btn_run_stop = 1'b1; btn_clear = 1'b1;
    step(8);
    check("multi_clear", clear, 1);
    step(1);
    check("multi_after_clear", clear, 0);
    check("multi_stop", run_stop, 0);
    step(1);
    check("multi_run", run_stop, 1);
    check("multi_mode_wait", mode, 0);
    step(1);
    check("multi_mode", mode, 1);
    check("multi_led_mode", led_mode, 2'b10);
    btn_mode = 1'b0; btn_run_stop = 1'b0; btn_clear = 1'b0;
    step(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
